coco_bank_mapper: RTL and testbench

- Parametrised cartridge memory mapper, successor to the single-window SDC expansion glue.
- Splits the 16KB cartridge ROM space $C000-$FFFF into NUM_WINDOWS independently banked windows, each with its own flash/SRAM select.
- Write access to the windows is gated by a timed $AA/$55 unlock sequence. A lock bit freezes the mapping until reset.
- Sits between the CoCo cartridge bus and the flash/SRAM chip enables. Also exposes ID/version readback in the $FF5x SCS space.

---
 rtl/coco_bank_mapper.sv | 130 +++++++++++++
 tb/tb_coco_bank_mapper.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/coco_bank_mapper.sv
// coco_bank_mapper: banked cartridge ROM window mapper with a timed unlock sequence and ID/version readback
//   clock, reset             system clock, synchronous active-high reset
//   bus_valid                one-cycle strobe per completed CPU bus cycle
//   e_high, address, r_w     CPU bus phase, address and direction (1 = read)
//   data_in/data_out/data_oe register write data, readback data and its bus drive enable
//   _cts, _scs, _rom_enable  cartridge ROM select, I/O select and external ROM switch
//   _cts_out                 gated ROM select
//   baddress                 bank of the addressed window
//   _ce_flash, _ce_sram, _we memory chip enables and write enable
//   prog_armed               unlock sequence armed
module coco_bank_mapper #(
    parameter int         NUM_WINDOWS    = 2,
    parameter int         BANK_BITS      = 5,
    parameter logic [2:0] REG_BASE       = 3'b011,
    parameter int         UNLOCK_TIMEOUT = 16,
    parameter logic [3:0] FAMILY         = 4'h2,
    parameter logic [3:0] DEV_ID         = 4'h4,
    parameter logic [3:0] VERSION        = 4'h1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 bus_valid,
    input  logic                 e_high,
    input  logic [15:0]          address,
    input  logic                 r_w,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic                 data_oe,
    input  logic                 _cts,
    input  logic                 _scs,
    input  logic                 _rom_enable,
    output logic                 _cts_out,
    output logic [BANK_BITS-1:0] baddress,
    output logic                 _ce_flash,
    output logic                 _ce_sram,
    output logic                 _we,
    output logic                 prog_armed
);
    localparam int WIN_LOG2 = NUM_WINDOWS == 4 ? 2 : NUM_WINDOWS == 2 ? 1 : 0;

    typedef enum logic [1:0] {IDLE = 2'd0, GOT_AA = 2'd1, ARMED = 2'd2} state_t;

    state_t               state, state_d;
    logic [7:0]           ctrl, ctrl_d, cnt, cnt_d;
    logic [BANK_BITS-1:0] bank [4];
    logic [BANK_BITS-1:0] bank_d [4];
    logic [3:0]           ram, ram_d;
    logic                 reg_sel, wr, ctrl_wr, lock, timeout, is_aa, keep_ctrl;
    logic [2:0]           idx;
    logic [1:0]           win;
    logic [7:0]           bank_rd;
    logic                 ce_mem;
    logic                 unused_addr;

    assign unused_addr = ^address[7:6];
    assign reg_sel     = !_scs && address[5:3] == REG_BASE;
    assign idx         = address[2:0];
    assign wr          = bus_valid && reg_sel && !r_w;
    assign lock        = ctrl[1];
    assign ctrl_wr     = wr && idx == 3'd0 && !lock;
    assign timeout     = cnt == 8'(UNLOCK_TIMEOUT - 1);
    assign is_aa       = data_in == 8'hAA;
    // $AA from IDLE/GOT_AA and $55 from GOT_AA advance the sequence without touching CTRL
    assign keep_ctrl   = is_aa || (state == GOT_AA && data_in == 8'h55);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ctrl_d  = ctrl;
        bank_d  = bank;
        ram_d   = ram;
        if (lock) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (ctrl_wr) begin
            cnt_d = '0;
            if (state == ARMED) begin
                state_d = IDLE;
                ctrl_d  = data_in;
            end else begin
                state_d = is_aa ? GOT_AA : keep_ctrl ? ARMED : IDLE;
                ctrl_d  = keep_ctrl ? ctrl : {data_in[7:1], ctrl[0]};
            end
        end else if (bus_valid && state != IDLE) begin
            state_d = timeout ? IDLE : state;
            cnt_d   = timeout ? '0 : cnt + 8'd1;
        end
        for (int n = 0; n < NUM_WINDOWS; n++) begin
            if (!lock && wr && idx == 3'(4 + n)) begin
                bank_d[n] = data_in[BANK_BITS-1:0];
                ram_d[n]  = data_in[7];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            ctrl  <= '0;
            ram   <= '0;
            for (int n = 0; n < 4; n++) bank[n] <= BANK_BITS'(n);
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ctrl  <= ctrl_d;
            ram   <= ram_d;
            bank  <= bank_d;
        end
    end

    // windows beyond NUM_WINDOWS are never written and always read back as 0
    assign bank_rd  = {1'b0, idx[1:0]} < 3'(NUM_WINDOWS) ? ({ram[idx[1:0]], 7'd0} | 8'(bank[idx[1:0]])) : 8'd0;
    assign data_oe  = reg_sel && r_w && e_high;
    assign data_out = !data_oe   ? 8'd0 :
                      idx == 3'd0 ? ctrl :
                      idx == 3'd1 ? {FAMILY, DEV_ID} :
                      idx == 3'd2 ? {VERSION, 2'b00, 2'(WIN_LOG2)} :
                      idx == 3'd3 ? {6'd0, state} : bank_rd;

    // top WIN_LOG2 bits of the 14-bit cartridge offset pick the window
    assign win        = 2'(address[13:12] >> (2 - WIN_LOG2));
    assign baddress   = bank[win];
    assign ce_mem     = !_cts || (ctrl[0] && !r_w && address[15:14] == 2'b11 && address[15:8] != 8'hFF);
    assign _ce_flash  = !(ce_mem && !ram[win]);
    assign _ce_sram   = !(ce_mem && ram[win]);
    assign _we        = !(!r_w && e_high);
    assign _cts_out   = !(_rom_enable && !_cts);
    assign prog_armed = state == ARMED;
endmodule

// File: tb/tb_coco_bank_mapper.sv
// tb_coco_bank_mapper: directed and randomized checks of coco_bank_mapper against a behavioural model
module tb_coco_bank_mapper;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, bus_valid, e_high, r_w, _cts, _scs, _rom_enable;
    logic [15:0] address;
    logic [7:0]  data_in, data_out;
    logic        data_oe, _cts_out, _ce_flash, _ce_sram, _we, prog_armed;
    logic [4:0]  baddress;

    coco_bank_mapper dut (
        .clock(clk), .reset(reset), .bus_valid(bus_valid), .e_high(e_high),
        .address(address), .r_w(r_w), .data_in(data_in), .data_out(data_out),
        .data_oe(data_oe), ._cts(_cts), ._scs(_scs), ._rom_enable(_rom_enable),
        ._cts_out(_cts_out), .baddress(baddress), ._ce_flash(_ce_flash),
        ._ce_sram(_ce_sram), ._we(_we), .prog_armed(prog_armed)
    );

    int n_chk = 0, n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // model state: CTRL byte, sequence step (0 idle, 1 saw $AA, 2 armed), strobes since step, bank bytes as read back
    logic [7:0] m_ctrl;
    logic [7:0] m_bank [2];
    int         m_st, m_cnt;
    logic       u_wr;
    int         u_idx;

    always @(posedge clk) begin
        u_wr  = bus_valid && !_scs && address[5:3] == 3'b011 && !r_w;
        u_idx = int'(address[2:0]);
        if (reset) begin
            m_ctrl = 8'h00; m_st = 0; m_cnt = 0;
            m_bank[0] = 8'h00; m_bank[1] = 8'h01;
        end else if (m_ctrl[1]) begin
            m_st = 0; m_cnt = 0;
        end else begin
            if (u_wr && u_idx == 0) begin
                m_cnt = 0;
                if (m_st == 2) begin m_ctrl = data_in; m_st = 0; end
                else if (data_in == 8'hAA) m_st = 1;
                else if (m_st == 1 && data_in == 8'h55) m_st = 2;
                else begin m_ctrl = {data_in[7:1], m_ctrl[0]}; m_st = 0; end
            end else if (bus_valid && m_st != 0) begin
                m_cnt++;
                if (m_cnt == 16) begin m_st = 0; m_cnt = 0; end
            end
            if (u_wr && (u_idx == 4 || u_idx == 5)) m_bank[u_idx-4] = data_in & 8'h9F;
        end
    end

    logic       c_sel, c_oe, c_ce, c_ram;
    logic [7:0] c_rd, c_bank;

    always @(negedge clk) begin
        if (chk_en) begin
            c_sel  = !_scs && address[5:3] == 3'b011;
            c_oe   = c_sel && r_w && e_high;
            case (address[2:0])
                3'd0:    c_rd = m_ctrl;
                3'd1:    c_rd = 8'h24;
                3'd2:    c_rd = 8'h11;
                3'd3:    c_rd = 8'(m_st);
                3'd4:    c_rd = m_bank[0];
                3'd5:    c_rd = m_bank[1];
                default: c_rd = 8'h00;
            endcase
            if (!c_oe) c_rd = 8'h00;
            c_bank = m_bank[address[13]];
            c_ram  = c_bank[7];
            c_ce   = !_cts || (m_ctrl[0] && !r_w && address >= 16'hC000 && address < 16'hFF00);
            chk("data_oe", data_oe, c_oe);
            chk("data_out", data_out, c_rd);
            chk("baddress", baddress, c_bank & 8'h1F);
            chk("_ce_flash", _ce_flash, !(c_ce && !c_ram));
            chk("_ce_sram", _ce_sram, !(c_ce && c_ram));
            chk("_we", _we, !(!r_w && e_high));
            chk("_cts_out", _cts_out, !(_rom_enable && !_cts));
            chk("prog_armed", prog_armed, m_st == 2);
        end
    end

    task automatic drive(logic [15:0] a, logic rw, logic [7:0] d, logic v, logic scs, logic cts, logic e);
        address = a; r_w = rw; data_in = d; bus_valid = v; _scs = scs; _cts = cts; e_high = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(logic [2:0] i, logic [7:0] d);
        drive({13'h1FEB, i}, 1'b0, d, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
    endtask

    task automatic rd_reg(logic [2:0] i, logic [7:0] exp, string nm);
        drive({13'h1FEB, i}, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk(nm, data_out, exp);
        tick();
    endtask

    task automatic mem(logic [15:0] a, logic rw, logic cts);
        drive(a, rw, 8'h00, 1'b0, 1'b1, cts, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; _rom_enable = 1'b1;
        drive(16'h0000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_ce_flash", _ce_flash, 1);
        chk("rst_ce_sram", _ce_sram, 1);
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        rd_reg(3'd1, 8'h24, "id");
        rd_reg(3'd2, 8'h11, "version");
        rd_reg(3'd3, 8'h00, "status_reset");
        mem(16'hC000, 1'b1, 1'b0);
        chk("win0_bank", baddress, 0);
        chk("win0_flash", _ce_flash, 0);
        tick();
        mem(16'hE000, 1'b1, 1'b0);
        chk("win1_bank", baddress, 1);
        tick();
        wr_reg(3'd5, 8'h83);
        mem(16'hE123, 1'b1, 1'b0);
        chk("bank1_addr", baddress, 3);
        chk("bank1_sram", _ce_sram, 0);
        chk("bank1_flash", _ce_flash, 1);
        tick();
        rd_reg(3'd5, 8'h83, "bank1_rd");
        wr_reg(3'd0, 8'hAA);
        wr_reg(3'd0, 8'h55);
        drive(16'h0000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("armed", prog_armed, 1);
        tick();
        rd_reg(3'd3, 8'h02, "status_armed");
        wr_reg(3'd0, 8'h01);
        rd_reg(3'd0, 8'h01, "ctrl_pe");
        mem(16'hC010, 1'b0, 1'b1);
        chk("prog_flash", _ce_flash, 0);
        chk("prog_we", _we, 0);
        tick();
        mem(16'hFF10, 1'b0, 1'b1);
        chk("prog_ff_flash", _ce_flash, 1);
        tick();
        wr_reg(3'd0, 8'hAA);
        wr_reg(3'd0, 8'h55);
        wr_reg(3'd0, 8'h00);
        rd_reg(3'd0, 8'h00, "ctrl_clear");
        wr_reg(3'd0, 8'hAA);
        for (int i = 0; i < 15; i++) begin
            drive(16'h1234, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
        end
        rd_reg(3'd3, 8'h01, "status_pre_to");
        drive(16'h1234, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        rd_reg(3'd3, 8'h00, "status_to");
        wr_reg(3'd0, 8'h55);
        rd_reg(3'd0, 8'h54, "ctrl_after_to");
        wr_reg(3'd0, 8'h01);
        rd_reg(3'd0, 8'h00, "ctrl_pe_kept");
        wr_reg(3'd0, 8'h02);
        rd_reg(3'd0, 8'h02, "ctrl_lock");
        wr_reg(3'd4, 8'h05);
        rd_reg(3'd4, 8'h00, "bank0_locked");
        wr_reg(3'd0, 8'hAA);
        rd_reg(3'd3, 8'h00, "status_locked");
        wr_reg(3'd0, 8'h55);
        wr_reg(3'd0, 8'h01);
        rd_reg(3'd0, 8'h02, "ctrl_locked");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_reg(3'd0, 8'h00, "lock_cleared");
        wr_reg(3'd5, 8'h83);
        wr_reg(3'd0, 8'hAA);
        wr_reg(3'd0, 8'h55);
        rd_reg(3'd3, 8'h02, "status_armed2");
        reset = 1'b1;
        drive(16'h0000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        reset = 1'b0;
        drive({13'h1FEB, 3'd3}, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("status_post_rst", data_out, 0);
        chk("armed_post_rst", prog_armed, 0);
        tick();
        rd_reg(3'd5, 8'h01, "bank1_post_rst");
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: address = {13'h1FEB, 3'($urandom)};
                4:          address = {10'h3FD, 6'($urandom)};
                5, 6, 7, 8: address = {2'b11, 14'($urandom)};
                default:    address = 16'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0:       data_in = 8'hAA;
                1:       data_in = 8'h55;
                default: data_in = 8'($urandom) & ($urandom_range(0, 9) == 0 ? 8'hFF : 8'hFD);
            endcase
            r_w         = 1'($urandom);
            bus_valid   = 1'($urandom);
            e_high      = 1'($urandom);
            _scs        = $urandom_range(0, 4) == 0;
            _cts        = 1'($urandom);
            _rom_enable = 1'($urandom);
            reset       = $urandom_range(0, 149) == 0;
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
